axi_loader: RTL and testbench

AXI_LOADER -- requirements
Module: axi_loader

---
 rtl/axi_loader_if.sv | 24 ++
 rtl/axi_loader.sv | 142 ++++++++++++++
 tb/tb_axi_loader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_loader_if.sv
// Single-beat AXI4 read channel (AR + R) between the loader (master) and host memory (slave).
interface axi_loader_if #(
  parameter int BRAM_DATA_WIDTH = 32
);
  logic [63:0]                araddr;
  logic [7:0]                 arlen;
  logic [2:0]                 arsize;
  logic                       arvalid;
  logic                       arready;
  logic [BRAM_DATA_WIDTH-1:0] rdata;
  logic [1:0]                 rresp;
  logic                       rvalid;
  logic                       rready;

  modport master (
    output araddr, arlen, arsize, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_loader.sv
// Copies READ_LENGTH words from host memory into a BRAM, one single-beat AXI read per word.
// Optional AXI_LOADER_RESP_CHECK_EN: error responses abort the load and set sticky load_error.
module axi_loader #(
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH = 12,
  parameter int READ_LENGTH     = 2048
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [63:0]                base_ptr,
  input  logic                       start_load,
  output logic                       load_idle,
  output logic                       load_error,
  output logic [BRAM_ADDR_WIDTH-1:0] addrb,
  output logic [BRAM_DATA_WIDTH-1:0] dinb,
  output logic                       web,
  output logic                       enb,
  axi_loader_if.master               axi
);

  localparam int                CNT_W          = $clog2(READ_LENGTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT       = CNT_W'(READ_LENGTH - 1);
  localparam logic [63:0]       BYTES_PER_WORD = 64'(BRAM_DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_ADDR,
    WAIT_DATA,
    WRITE_BRAM,
    CHECK
  } state_t;

  state_t                     state;
  logic [CNT_W-1:0]           word_cnt;
  logic [63:0]                byte_addr;
  logic [BRAM_DATA_WIDTH-1:0] data_q;
  logic                       arvalid_q;
  logic                       rready_q;
  logic                       wr_q;
  logic                       load_idle_q;
`ifdef AXI_LOADER_RESP_CHECK_EN
  logic                       load_error_q;
`endif

  // byte_addr only moves in IDLE and CHECK, so araddr is stable for the whole PUSH_ADDR phase
  assign axi.araddr  = byte_addr;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'($clog2(BRAM_DATA_WIDTH / 8));
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign addrb     = BRAM_ADDR_WIDTH'(word_cnt);
  assign dinb      = data_q;
  assign web       = wr_q;
  assign enb       = wr_q;
  assign load_idle = load_idle_q;
`ifdef AXI_LOADER_RESP_CHECK_EN
  assign load_error = load_error_q;
`else
  assign load_error = 1'b0;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      wr_q         <= 1'b0;
      load_idle_q  <= 1'b1;
      word_cnt     <= '0;
      byte_addr    <= '0;
`ifdef AXI_LOADER_RESP_CHECK_EN
      load_error_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          byte_addr <= base_ptr;
          word_cnt  <= '0;
          if (start_load) begin
            state       <= PUSH_ADDR;
            arvalid_q   <= 1'b1;
            load_idle_q <= 1'b0;
`ifdef AXI_LOADER_RESP_CHECK_EN
            load_error_q <= 1'b0;
`endif
          end
        end
        PUSH_ADDR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (axi.rvalid) begin
            rready_q <= 1'b0;
`ifdef AXI_LOADER_RESP_CHECK_EN
            // a failed beat ends the load; words already written stay in the BRAM
            if (axi.rresp != 2'b00) begin
              load_error_q <= 1'b1;
              load_idle_q  <= 1'b1;
              state        <= IDLE;
            end else begin
              wr_q  <= 1'b1;
              state <= WRITE_BRAM;
            end
`else
            wr_q  <= 1'b1;
            state <= WRITE_BRAM;
`endif
          end
        end
        WRITE_BRAM: begin
          wr_q  <= 1'b0;
          state <= CHECK;
        end
        CHECK: begin
          if (word_cnt == LAST_CNT) begin
            load_idle_q <= 1'b1;
            state       <= IDLE;
          end else begin
            byte_addr <= byte_addr + BYTES_PER_WORD;
            word_cnt  <= word_cnt + CNT_W'(1);
            arvalid_q <= 1'b1;
            state     <= PUSH_ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is captured without reset; it is only consumed in WRITE_BRAM
  always_ff @(posedge aclk) begin
    if (state == WAIT_DATA && axi.rvalid) begin
      data_q <= axi.rdata;
    end
  end

endmodule

// File: tb/tb_axi_loader.sv
// Scoreboard bench for axi_loader: directed loads against a delay-programmable AXI read slave.
`timescale 1ns/1ps
module tb_axi_loader;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int RL = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic [63:0]   base_ptr;
  logic          start_load;
  logic          load_idle;
  logic          load_error;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dinb;
  logic          web;
  logic          enb;

  axi_loader_if #(.BRAM_DATA_WIDTH(DW)) axi ();

  axi_loader #(
    .BRAM_DATA_WIDTH(DW),
    .BRAM_ADDR_WIDTH(AW),
    .READ_LENGTH    (RL)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .base_ptr  (base_ptr),
    .start_load(start_load),
    .load_idle (load_idle),
    .load_error(load_error),
    .addrb     (addrb),
    .dinb      (dinb),
    .web       (web),
    .enb       (enb),
    .axi       (axi)
  );

  always #5 aclk = ~aclk;

  int            n_cmp = 0;
  int            n_err = 0;
  int            ar_delay = 0;
  int            r_delay = 0;
  int            err_word = -1;
  int            ar_seen = 0;
  logic [31:0]   data_hi = '0;
  logic [63:0]   cur_base = '0;
  logic [63:0]   exp_ar[$];
  logic [AW+DW-1:0] exp_wr[$];
  logic [DW-1:0] bram [0:15];

  always @(posedge aclk) begin
    if (enb && web) bram[addrb[3:0]] <= dinb;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] base, input logic [31:0] hi, input int n, input int skip);
    for (int i = 0; i < n; i++) begin
      exp_ar.push_back(base + 64'(4 * i));
      if (i != skip) exp_wr.push_back({AW'(i), hi + 32'(i)});
    end
  endtask

  task automatic kick(input logic [63:0] base);
    @(negedge aclk);
    base_ptr   = base;
    start_load = 1'b1;
    @(negedge aclk);
    chk("load_idle_busy", {63'd0, load_idle}, 64'd0);
    start_load = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (!load_idle && cycles < budget) begin
      @(negedge aclk);
      cycles++;
    end
    if (!load_idle) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: load_idle still 0 after %0d cycles, required 1", cycles);
    end
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_ar_left"}, 64'(exp_ar.size()), 64'd0);
    chk({tag, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
  endtask

  // AXI read slave: programmable AR and R delays, data = data_hi + word index
  initial begin : slave
    int st, cnt, idx;
    bit ar_fire, r_fire;
    logic [63:0] a;
    st = 0; cnt = 0; idx = 0; ar_fire = 0; r_fire = 0; a = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
    forever begin
      @(posedge aclk); #1;
      if (areset) begin
        st = 0; ar_fire = 0; r_fire = 0;
        axi.arready = 1'b0; axi.rvalid = 1'b0;
      end else begin
        if (ar_fire) begin axi.arready = 1'b0; cnt = r_delay; st = 2; end
        if (r_fire)  begin axi.rvalid = 1'b0; st = 0; end
        if (st == 0 && axi.arvalid) begin a = axi.araddr; cnt = ar_delay; st = 1; end
        if (st == 1) begin
          if (cnt == 0) axi.arready = 1'b1; else cnt--;
        end else if (st == 2 && !axi.rvalid) begin
          if (cnt == 0) begin
            idx = int'((a - cur_base) >> 2);
            axi.rdata  = data_hi + 32'(idx);
            axi.rresp  = (idx == err_word) ? 2'b10 : 2'b00;
            axi.rvalid = 1'b1;
          end else cnt--;
        end
        ar_fire = (st == 1) && axi.arready && axi.arvalid;
        r_fire  = (st == 2) && axi.rvalid && axi.rready;
      end
    end
  end

  // Monitor: pops expected AR addresses and BRAM writes as the DUT presents them
  initial begin : monitor
    logic prev_arv, prev_hs, prev_web;
    logic [63:0] prev_addr;
    prev_arv = 0; prev_hs = 0; prev_web = 0; prev_addr = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_arv = 0; prev_hs = 0; prev_web = 0;
      end else begin
        if (prev_arv && !prev_hs) begin
          chk("arvalid_hold", {63'd0, axi.arvalid}, 64'd1);
          chk("araddr_hold", axi.araddr, prev_addr);
        end
        if (axi.arvalid && axi.arready) begin
          ar_seen++;
          if (exp_ar.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL ar_unexpected: araddr 0x%0h issued, no request expected", axi.araddr);
          end else begin
            chk("araddr", axi.araddr, exp_ar.pop_front());
            chk("arlen", 64'(axi.arlen), 64'd0);
            chk("arsize", 64'(axi.arsize), 64'd2);
          end
        end
        if (web || enb) chk("enb_vs_web", {63'd0, enb}, {63'd0, web});
        if (web) begin
          chk("web_single_pulse", {63'd0, prev_web}, 64'd0);
          if (exp_wr.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wr_unexpected: addrb %0d dinb 0x%0h written, no write expected", addrb, dinb);
          end else begin
            chk("bram_write", 64'({addrb, dinb}), 64'(exp_wr.pop_front()));
          end
        end
        prev_arv  = axi.arvalid;
        prev_hs   = axi.arvalid && axi.arready;
        prev_addr = axi.araddr;
        prev_web  = web;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    int c, k, s0;
    areset = 1'b1; start_load = 1'b0; base_ptr = '0;
    @(negedge aclk);
    chk("rst_load_idle", {63'd0, load_idle}, 64'd1);
    chk("rst_load_error", {63'd0, load_error}, 64'd0);
    chk("rst_arvalid", {63'd0, axi.arvalid}, 64'd0);
    chk("rst_rready", {63'd0, axi.rready}, 64'd0);
    chk("rst_web_enb", {62'd0, web, enb}, 64'd0);
    chk("rst_araddr", axi.araddr, 64'd0);
    @(negedge aclk);
    areset = 1'b0;

    // zero-wait load of 4 words
    cur_base = 64'h1000; data_hi = 32'hA0; ar_delay = 0; r_delay = 0;
    push_exp(64'h1000, 32'hA0, 4, -1);
    kick(64'h1000);
    wait_idle(200, c);
    chk("t1_idle_latency", 64'(c + 1), 64'd17);
    for (int i = 0; i < 4; i++) chk("t1_bram", 64'(bram[i]), 64'(32'hA0 + i));
    chk_empty("t1");

    // stalled slave
    cur_base = 64'h3000; data_hi = 32'hB0; ar_delay = 3; r_delay = 5;
    push_exp(64'h3000, 32'hB0, 4, -1);
    kick(64'h3000);
    wait_idle(400, c);
    for (int i = 0; i < 4; i++) chk("t2_bram", 64'(bram[i]), 64'(32'hB0 + i));
    chk_empty("t2");

    // reset while waiting for data of word 2
    cur_base = 64'h1000; data_hi = 32'hC0; ar_delay = 0; r_delay = 3;
    push_exp(64'h1000, 32'hC0, 3, 2);
    s0 = ar_seen;
    kick(64'h1000);
    k = 0;
    while (!(ar_seen == s0 + 3 && axi.rready === 1'b1) && k < 300) begin
      @(negedge aclk);
      k++;
    end
    chk("t3_reached_word2_wait", {63'd0, axi.rready}, 64'd1);
    areset = 1'b1;
    #1;
    chk("t3_arvalid", {63'd0, axi.arvalid}, 64'd0);
    chk("t3_rready", {63'd0, axi.rready}, 64'd0);
    chk("t3_web_enb", {62'd0, web, enb}, 64'd0);
    chk("t3_load_idle", {63'd0, load_idle}, 64'd1);
    chk("t3_araddr", axi.araddr, 64'd0);
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    chk_empty("t3");
    chk("t3_bram0", 64'(bram[0]), 64'h0C0);
    chk("t3_bram1", 64'(bram[1]), 64'h0C1);
    chk("t3_bram2_kept", 64'(bram[2]), 64'h0B2);

    cur_base = 64'h2000; data_hi = 32'hD0; ar_delay = 0; r_delay = 0;
    push_exp(64'h2000, 32'hD0, 4, -1);
    kick(64'h2000);
    wait_idle(200, c);
    chk("t3r_idle_latency", 64'(c + 1), 64'd17);
    for (int i = 0; i < 4; i++) chk("t3r_bram", 64'(bram[i]), 64'(32'hD0 + i));
    chk_empty("t3r");

    // error response on word 1
    cur_base = 64'h4000; data_hi = 32'hE0; err_word = 1;
`ifdef AXI_LOADER_RESP_CHECK_EN
    push_exp(64'h4000, 32'hE0, 2, 1);
    kick(64'h4000);
    wait_idle(200, c);
    repeat (3) @(negedge aclk);
    chk("t4_load_error", {63'd0, load_error}, 64'd1);
    chk("t4_load_idle", {63'd0, load_idle}, 64'd1);
    chk("t4_bram0", 64'(bram[0]), 64'h0E0);
    chk("t4_bram1_kept", 64'(bram[1]), 64'h0D1);
`else
    push_exp(64'h4000, 32'hE0, 4, -1);
    kick(64'h4000);
    wait_idle(200, c);
    chk("t4_load_error", {63'd0, load_error}, 64'd0);
    for (int i = 0; i < 4; i++) chk("t4_bram", 64'(bram[i]), 64'(32'hE0 + i));
`endif
    chk_empty("t4");
    err_word = -1;

    // start_load held: back-to-back loads with one IDLE cycle, mid-load pulse and base change ignored
    cur_base = 64'h5000; data_hi = 32'hF0;
    push_exp(64'h5000, 32'hF0, 4, -1);
    push_exp(64'h5000, 32'hF0, 4, -1);
    @(negedge aclk);
    base_ptr = 64'h5000; start_load = 1'b1;
    @(negedge aclk);
    chk("t5_load_idle_busy", {63'd0, load_idle}, 64'd0);
    chk("t5_error_cleared", {63'd0, load_error}, 64'd0);
    wait_idle(200, c);
    chk("t5_idle_latency", 64'(c + 1), 64'd17);
    @(negedge aclk);
    chk("t5_one_idle_cycle", {63'd0, load_idle}, 64'd0);
    start_load = 1'b0;
    base_ptr   = 64'hDEAD_0000;
    repeat (5) @(negedge aclk);
    start_load = 1'b1;
    @(negedge aclk);
    start_load = 1'b0;
    wait_idle(200, c);
    repeat (12) @(negedge aclk);
    chk("t5_stays_idle", {63'd0, load_idle}, 64'd1);
    for (int i = 0; i < 4; i++) chk("t5_bram", 64'(bram[i]), 64'(32'hF0 + i));
    chk_empty("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
